// File: rtl/flag_buf_arb_pkg.sv
// Shared types, constants and helpers for the flag_buf_arb mailbox.
// Default build needs no macro; FLAG_BUF_ARB_TIMEOUT_EN enables the read watchdog.
package flag_buf_arb_pkg;

  localparam int DEF_N = 4;
  localparam int DEF_W = 8;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  localparam int DEF_IDW = clog2(DEF_N);

endpackage

// File: rtl/flag_buf_arb_if.sv
// Producer/consumer bundle for flag_buf_arb: master drives requests and
// clears, slave (the mailbox) returns grant, flag, data and source index.
interface flag_buf_arb_if
  import flag_buf_arb_pkg::*;
#(
  parameter int N   = DEF_N,
  parameter int W   = DEF_W,
  parameter int IDW = DEF_IDW
) ();

  logic [N-1:0]   req;
  logic [N*W-1:0] din;
  logic [N-1:0]   grant;
  logic           clr_flag;
  logic           flag;
  logic [W-1:0]   dout;
  logic [IDW-1:0] src_id;
  logic           timeout;

  modport master (
    output req, din, clr_flag,
    input  grant, flag, dout, src_id, timeout
  );

  modport slave (
    input  req, din, clr_flag,
    output grant, flag, dout, src_id, timeout
  );

endinterface

// File: rtl/flag_buf_arb_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping past N-1 back to 0.
module rr_arbiter #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] ptr_i,
  output logic           valid_o,
  output logic [IDW-1:0] index_o,
  output logic [N-1:0]   onehot_o
);

  int j;

  always_comb begin
    valid_o  = |req_i;
    index_o  = '0;
    onehot_o = '0;
    j        = 0;
    // Walk offsets from farthest to nearest so the nearest hit wins.
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr_i) + k;
      if (j >= N) j = j - N;
      if (req_i[j]) index_o = IDW'(j);
    end
    if (valid_o) onehot_o[index_o] = 1'b1;
  end

endmodule

// File: rtl/flag_buf_arb.sv
// Single-word mailbox shared by N producers via round-robin grant.
// Define FLAG_BUF_ARB_TIMEOUT_EN to discard words left unread for TO_CYCLES cycles.
module flag_buf_arb
  import flag_buf_arb_pkg::*;
#(
  parameter int N         = DEF_N,
  parameter int W         = DEF_W,
  parameter int IDW       = DEF_IDW,
  parameter int TO_CYCLES = 1024
) (
  input  logic          clk,
  input  logic          reset,
  flag_buf_arb_if.slave bus
);

  if (N < 2 || N > 16 || (1 << IDW) < N || TO_CYCLES < 2) begin : g_bad_param
    $error("flag_buf_arb: illegal parameter set");
  end

  state_e         state_q, state_d;
  logic [W-1:0]   dout_q, dout_d;
  logic [IDW-1:0] src_q, src_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [N-1:0]   grant_c;
  logic           acc;
  logic           clr_eff;
  logic           force_clr;

  logic           arb_valid;
  logic [IDW-1:0] arb_index;
  logic [N-1:0]   arb_onehot;
  logic [W-1:0]   din_arr [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_din
    assign din_arr[gi] = bus.din[gi*W +: W];
  end

  rr_arbiter #(
    .N   (N),
    .IDW (IDW)
  ) u_arb (
    .req_i    (bus.req),
    .ptr_i    (ptr_q),
    .valid_o  (arb_valid),
    .index_o  (arb_index),
    .onehot_o (arb_onehot)
  );

  // A watchdog discard behaves exactly like a consumer clear.
  assign clr_eff = bus.clr_flag | force_clr;
  assign acc     = ((state_q == ST_EMPTY) || clr_eff) && arb_valid;

  always_comb begin
    state_d = state_q;
    dout_d  = dout_q;
    src_d   = src_q;
    ptr_d   = ptr_q;
    grant_c = '0;
    if (acc) begin
      state_d = ST_FULL;
      dout_d  = din_arr[arb_index];
      src_d   = arb_index;
      ptr_d   = (arb_index == IDW'(N - 1)) ? '0 : arb_index + 1'b1;
      grant_c = arb_onehot;
    end else if (state_q == ST_FULL && clr_eff) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      dout_q  <= '0;
      src_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      dout_q  <= dout_d;
      src_q   <= src_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef FLAG_BUF_ARB_TIMEOUT_EN
  localparam int CW = clog2(TO_CYCLES + 1);

  logic [CW-1:0] to_cnt_q, to_cnt_d;
  logic          timeout_q;

  assign force_clr = (state_q == ST_FULL) && !bus.clr_flag &&
                     (to_cnt_q == CW'(TO_CYCLES - 1));

  // Only an unattended FULL word ages; every other case restarts the count.
  always_comb begin
    to_cnt_d = '0;
    if (state_q == ST_FULL && !bus.clr_flag && !force_clr) to_cnt_d = to_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      timeout_q <= force_clr;
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign force_clr   = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  assign bus.grant  = grant_c;
  assign bus.flag   = (state_q == ST_FULL);
  assign bus.dout   = dout_q;
  assign bus.src_id = src_q;

endmodule
